// File: rtl/int_wb_pipereg.sv
// Writeback pipeline register for the integer execution block: captures results,
// arbitrates integer vs memory redirects by ROB age, and drives a one-cycle flush pulse.
module int_wb_pipereg #(
    parameter int ROBID_W = 7,
    parameter int SQID_W  = 6
) (
    input  logic               clock,
    input  logic               reset_n,

    input  logic               in_instr_valid,
    input  logic               in_need_to_wb,
    input  logic [5:0]         in_prd,
    input  logic [63:0]        in_result,
    input  logic [ROBID_W-1:0] in_robid,
    input  logic [SQID_W-1:0]  in_sqid,
    input  logic [63:0]        in_pc,
    input  logic [31:0]        in_instr,
    input  logic               in_redirect_valid,
    input  logic [63:0]        in_redirect_target,

    input  logic               mem_redirect_valid,
    input  logic [ROBID_W-1:0] mem_redirect_robid,
    input  logic [63:0]        mem_redirect_target,

    input  logic               rob_flush,

    output logic               out_instr_valid,
    output logic               out_need_to_wb,
    output logic [5:0]         out_prd,
    output logic [63:0]        out_result,
    output logic [ROBID_W-1:0] out_robid,
    output logic [SQID_W-1:0]  out_sqid,
    output logic [63:0]        out_pc,
    output logic [31:0]        out_instr,

    output logic               flush_valid,
    output logic [ROBID_W-1:0] flush_robid,
    output logic [63:0]        flush_target,
    output logic [31:0]        redirect_cnt
);

    localparam int IDX_W = ROBID_W - 1;

    // The wrap flag flips the sense of the index compare once one id has lapped the ROB.
    function automatic logic older(input logic [ROBID_W-1:0] a, input logic [ROBID_W-1:0] b);
        return (a[ROBID_W-1] ^ b[ROBID_W-1]) ^ (a[IDX_W-1:0] < b[IDX_W-1:0]);
    endfunction

    logic               kill;
    logic               int_cand;
    logic               int_wins;
    logic               capture;
    logic [ROBID_W-1:0] cap_robid;
    logic [63:0]        cap_target;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        kill       = 1'b0;
        int_cand   = 1'b0;
        int_wins   = 1'b0;
        capture    = 1'b0;
        cap_robid  = mem_redirect_robid;
        cap_target = mem_redirect_target;

        kill     = rob_flush | (mem_redirect_valid & older(mem_redirect_robid, in_robid));
        int_cand = in_redirect_valid & in_instr_valid & ~kill;
        // Equal ids are never older, so a tie falls to the memory redirect.
        int_wins = int_cand & (~mem_redirect_valid | older(in_robid, mem_redirect_robid));
        capture  = ~rob_flush & (int_cand | mem_redirect_valid);

        if (int_wins) begin
            cap_robid  = in_robid;
            cap_target = in_redirect_target;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: data registers are cleared too, so every output reads 0 during reset.
            out_instr_valid <= 1'b0;
            out_need_to_wb  <= 1'b0;
            out_prd         <= '0;
            out_result      <= '0;
            out_robid       <= '0;
            out_sqid        <= '0;
            out_pc          <= '0;
            out_instr       <= '0;
            flush_valid     <= 1'b0;
            flush_robid     <= '0;
            flush_target    <= '0;
            redirect_cnt    <= '0;
        end else begin
            out_instr_valid <= in_instr_valid & ~kill;
            out_need_to_wb  <= in_need_to_wb;
            out_prd         <= in_prd;
            out_result      <= in_result;
            out_robid       <= in_robid;
            out_sqid        <= in_sqid;
            out_pc          <= in_pc;
            out_instr       <= in_instr;

            flush_valid <= capture;
            if (capture) begin
                flush_robid  <= cap_robid;
                flush_target <= cap_target;
                redirect_cnt <= redirect_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_int_wb_pipereg.sv
// Self-checking bench for int_wb_pipereg: table of one-cycle vectors with hand-computed
// expectations, plus reset and mid-pulse asynchronous reset sequences.
module tb_int_wb_pipereg;

    logic        clock;
    logic        reset_n;
    logic        in_instr_valid;
    logic        in_need_to_wb;
    logic [5:0]  in_prd;
    logic [63:0] in_result;
    logic [6:0]  in_robid;
    logic [5:0]  in_sqid;
    logic [63:0] in_pc;
    logic [31:0] in_instr;
    logic        in_redirect_valid;
    logic [63:0] in_redirect_target;
    logic        mem_redirect_valid;
    logic [6:0]  mem_redirect_robid;
    logic [63:0] mem_redirect_target;
    logic        rob_flush;
    logic        out_instr_valid;
    logic        out_need_to_wb;
    logic [5:0]  out_prd;
    logic [63:0] out_result;
    logic [6:0]  out_robid;
    logic [5:0]  out_sqid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        flush_valid;
    logic [6:0]  flush_robid;
    logic [63:0] flush_target;
    logic [31:0] redirect_cnt;

    int n_checks = 0;
    int n_errors = 0;

    int_wb_pipereg #(.ROBID_W(7), .SQID_W(6)) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .in_instr_valid      (in_instr_valid),
        .in_need_to_wb       (in_need_to_wb),
        .in_prd              (in_prd),
        .in_result           (in_result),
        .in_robid            (in_robid),
        .in_sqid             (in_sqid),
        .in_pc               (in_pc),
        .in_instr            (in_instr),
        .in_redirect_valid   (in_redirect_valid),
        .in_redirect_target  (in_redirect_target),
        .mem_redirect_valid  (mem_redirect_valid),
        .mem_redirect_robid  (mem_redirect_robid),
        .mem_redirect_target (mem_redirect_target),
        .rob_flush           (rob_flush),
        .out_instr_valid     (out_instr_valid),
        .out_need_to_wb      (out_need_to_wb),
        .out_prd             (out_prd),
        .out_result          (out_result),
        .out_robid           (out_robid),
        .out_sqid            (out_sqid),
        .out_pc              (out_pc),
        .out_instr           (out_instr),
        .flush_valid         (flush_valid),
        .flush_robid         (flush_robid),
        .flush_target        (flush_target),
        .redirect_cnt        (redirect_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        iv;
        logic        wb;
        logic [5:0]  prd;
        logic [63:0] result;
        logic [6:0]  robid;
        logic [5:0]  sqid;
        logic        rv;
        logic [63:0] rtgt;
        logic        mv;
        logic [6:0]  mrobid;
        logic [63:0] mtgt;
        logic        rf;
        logic        exp_ov;
        logic        exp_fv;
        logic [6:0]  exp_frobid;
        logic [63:0] exp_ftgt;
        logic [31:0] exp_cnt;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        in_instr_valid      = 1'b0;
        in_need_to_wb       = 1'b0;
        in_prd              = '0;
        in_result           = '0;
        in_robid            = '0;
        in_sqid             = '0;
        in_pc               = '0;
        in_instr            = '0;
        in_redirect_valid   = 1'b0;
        in_redirect_target  = '0;
        mem_redirect_valid  = 1'b0;
        mem_redirect_robid  = '0;
        mem_redirect_target = '0;
        rob_flush           = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " out_instr_valid"}, {63'd0, out_instr_valid}, 64'd0);
        check({tag, " out_need_to_wb"},  {63'd0, out_need_to_wb},  64'd0);
        check({tag, " out_prd"},         {58'd0, out_prd},         64'd0);
        check({tag, " out_result"},      out_result,               64'd0);
        check({tag, " out_robid"},       {57'd0, out_robid},       64'd0);
        check({tag, " out_sqid"},        {58'd0, out_sqid},        64'd0);
        check({tag, " out_pc"},          out_pc,                   64'd0);
        check({tag, " out_instr"},       {32'd0, out_instr},       64'd0);
        check({tag, " flush_valid"},     {63'd0, flush_valid},     64'd0);
        check({tag, " flush_robid"},     {57'd0, flush_robid},     64'd0);
        check({tag, " flush_target"},    flush_target,             64'd0);
        check({tag, " redirect_cnt"},    {32'd0, redirect_cnt},    64'd0);
    endtask

    initial begin
        //        iv    wb    prd     result          robid  sqid   rv    rtgt                mv    mrobid mtgt          rf      ov    fv    frobid ftgt                cnt
        vecs[0]  = '{1'b1, 1'b1, 6'd5,  64'h1234, 7'h03, 6'd2,  1'b0, 64'h0,           1'b0, 7'h00, 64'h0,    1'b0,   1'b1, 1'b0, 7'h00, 64'h0,           32'd0};
        vecs[1]  = '{1'b1, 1'b1, 6'd7,  64'hAAAA, 7'h10, 6'd3,  1'b1, 64'h8000_0100,   1'b0, 7'h00, 64'h0,    1'b0,   1'b1, 1'b1, 7'h10, 64'h8000_0100,   32'd1};
        vecs[2]  = '{1'b0, 1'b0, 6'd0,  64'h0,    7'h00, 6'd0,  1'b0, 64'h0,           1'b0, 7'h00, 64'h0,    1'b0,   1'b0, 1'b0, 7'h00, 64'h0,           32'd1};
        vecs[3]  = '{1'b1, 1'b1, 6'd9,  64'h3333, 7'h0C, 6'd4,  1'b1, 64'h9000,        1'b1, 7'h08, 64'hA000, 1'b0,   1'b0, 1'b1, 7'h08, 64'hA000,        32'd2};
        vecs[4]  = '{1'b1, 1'b0, 6'd10, 64'h4444, 7'h3F, 6'd5,  1'b1, 64'hB000,        1'b1, 7'h41, 64'hC000, 1'b0,   1'b1, 1'b1, 7'h3F, 64'hB000,        32'd3};
        vecs[5]  = '{1'b1, 1'b1, 6'd11, 64'h5555, 7'h20, 6'd6,  1'b1, 64'hC100,        1'b0, 7'h00, 64'h0,    1'b1,   1'b0, 1'b0, 7'h00, 64'h0,           32'd3};
        vecs[6]  = '{1'b1, 1'b1, 6'd12, 64'h6666, 7'h15, 6'd7,  1'b1, 64'hD000,        1'b1, 7'h15, 64'hE000, 1'b0,   1'b1, 1'b1, 7'h15, 64'hE000,        32'd4};
        vecs[7]  = '{1'b1, 1'b1, 6'd13, 64'h7777, 7'h05, 6'd8,  1'b0, 64'h0,           1'b1, 7'h09, 64'hF000, 1'b0,   1'b1, 1'b1, 7'h09, 64'hF000,        32'd5};
        vecs[8]  = '{1'b1, 1'b1, 6'd14, 64'h8888, 7'h30, 6'd9,  1'b1, 64'h1100,        1'b1, 7'h31, 64'h2200, 1'b0,   1'b1, 1'b1, 7'h30, 64'h1100,        32'd6};
        vecs[9]  = '{1'b1, 1'b1, 6'd15, 64'h9999, 7'h00, 6'd10, 1'b1, 64'h3300,        1'b1, 7'h7F, 64'h4400, 1'b0,   1'b0, 1'b1, 7'h7F, 64'h4400,        32'd7};
        vecs[10] = '{1'b0, 1'b1, 6'd16, 64'hAAAA, 7'h11, 6'd11, 1'b1, 64'h5500,        1'b0, 7'h00, 64'h0,    1'b0,   1'b0, 1'b0, 7'h00, 64'h0,           32'd7};
        vecs[11] = '{1'b1, 1'b1, 6'd17, 64'hBBBB, 7'h22, 6'd12, 1'b0, 64'h0,           1'b1, 7'h10, 64'h6600, 1'b1,   1'b0, 1'b0, 7'h00, 64'h0,           32'd7};
        vecs[12] = '{1'b0, 1'b0, 6'd0,  64'h0,    7'h00, 6'd0,  1'b0, 64'h0,           1'b0, 7'h00, 64'h0,    1'b0,   1'b0, 1'b0, 7'h00, 64'h0,           32'd7};

        reset_n = 1'b0;
        drive_idle();
        #3;
        check_all_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < NVEC; i++) begin
            in_instr_valid      = vecs[i].iv;
            in_need_to_wb       = vecs[i].wb;
            in_prd              = vecs[i].prd;
            in_result           = vecs[i].result;
            in_robid            = vecs[i].robid;
            in_sqid             = vecs[i].sqid;
            in_pc               = 64'h1000 + 64'(i * 4);
            in_instr            = 32'h13 + 32'(i);
            in_redirect_valid   = vecs[i].rv;
            in_redirect_target  = vecs[i].rtgt;
            mem_redirect_valid  = vecs[i].mv;
            mem_redirect_robid  = vecs[i].mrobid;
            mem_redirect_target = vecs[i].mtgt;
            rob_flush           = vecs[i].rf;
            step();
            check($sformatf("v%0d out_instr_valid", i), {63'd0, out_instr_valid}, {63'd0, vecs[i].exp_ov});
            check($sformatf("v%0d flush_valid", i),     {63'd0, flush_valid},     {63'd0, vecs[i].exp_fv});
            check($sformatf("v%0d redirect_cnt", i),    {32'd0, redirect_cnt},    {32'd0, vecs[i].exp_cnt});
            if (vecs[i].exp_ov) begin
                check($sformatf("v%0d out_need_to_wb", i), {63'd0, out_need_to_wb}, {63'd0, vecs[i].wb});
                check($sformatf("v%0d out_prd", i),    {58'd0, out_prd},   {58'd0, vecs[i].prd});
                check($sformatf("v%0d out_result", i), out_result,         vecs[i].result);
                check($sformatf("v%0d out_robid", i),  {57'd0, out_robid}, {57'd0, vecs[i].robid});
                check($sformatf("v%0d out_sqid", i),   {58'd0, out_sqid},  {58'd0, vecs[i].sqid});
                check($sformatf("v%0d out_pc", i),     out_pc,             64'h1000 + 64'(i * 4));
                check($sformatf("v%0d out_instr", i),  {32'd0, out_instr}, {32'd0, 32'h13 + 32'(i)});
            end
            if (vecs[i].exp_fv) begin
                check($sformatf("v%0d flush_robid", i),  {57'd0, flush_robid}, {57'd0, vecs[i].exp_frobid});
                check($sformatf("v%0d flush_target", i), flush_target,         vecs[i].exp_ftgt);
            end
        end

        // Asynchronous reset in the middle of a flush pulse.
        drive_idle();
        in_instr_valid     = 1'b1;
        in_robid           = 7'h2A;
        in_redirect_valid  = 1'b1;
        in_redirect_target = 64'hDEAD_0000;
        step();
        check("pre-reset flush_valid", {63'd0, flush_valid}, 64'd1);
        check("pre-reset redirect_cnt", {32'd0, redirect_cnt}, 64'd8);
        drive_idle();
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("midpulse reset");
        @(negedge clock);
        reset_n = 1'b1;

        // First capture lands on the first rising edge after release.
        in_instr_valid     = 1'b1;
        in_robid           = 7'h05;
        in_redirect_valid  = 1'b1;
        in_redirect_target = 64'h0000_BEEF;
        step();
        check("post-reset flush_valid",  {63'd0, flush_valid},  64'd1);
        check("post-reset flush_robid",  {57'd0, flush_robid},  64'h05);
        check("post-reset flush_target", flush_target,          64'hBEEF);
        check("post-reset redirect_cnt", {32'd0, redirect_cnt}, 64'd1);
        drive_idle();
        step();
        check("pulse end flush_valid", {63'd0, flush_valid}, 64'd0);
        check("pulse end redirect_cnt", {32'd0, redirect_cnt}, 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/int_wb_pipereg.md
# int_wb_pipereg

Writeback pipeline register directly downstream of the integer execution block. It captures the block's per-cycle result and redirect, arbitrates that redirect against a concurrent memory-pipeline redirect, and drops any captured instruction that is younger than an accepted flush. It drives the registered flush (`flush_valid` / `flush_robid`) back to the integer execution block and forward to the frontend and ROB, plus a redirect event counter for the PMU.

## Interface
Parameters:
- `ROBID_W`, 7, ROB id width; MSB is the wrap flag, low `ROBID_W-1` bits are the index.
- `SQID_W`, 6, store-queue id width (`SQ_SIZE_LOG+1`).

Ports (clock and reset first):
- `clock` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_instr_valid` in 1: result valid from the integer execution block.
- `in_need_to_wb` in 1: result writes the physical register file.
- `in_prd` in 6: destination physical register.
- `in_result` in 64: result.
- `in_robid` in `ROBID_W`: ROB id.
- `in_sqid` in `SQID_W`: store-queue id.
- `in_pc` in 64: PC (debug).
- `in_instr` in 32: instruction (debug).
- `in_redirect_valid` in 1: branch mispredict redirect.
- `in_redirect_target` in 64: redirect target.
- `mem_redirect_valid` in 1: memory-pipeline redirect.
- `mem_redirect_robid` in `ROBID_W`: ROB id of the memory redirect.
- `mem_redirect_target` in 64: memory redirect target.
- `rob_flush` in 1: commit-time global flush; kills everything.
- `out_instr_valid`, `out_need_to_wb`, `out_prd`, `out_result`, `out_robid`, `out_sqid`, `out_pc`, `out_instr` out: registered copies of the `in_*` fields.
- `flush_valid` out 1: registered redirect.
- `flush_robid` out `ROBID_W`: ROB id of the redirecting instruction.
- `flush_target` out 64: redirect target.
- `redirect_cnt` out 32: count of accepted redirects.

## Operation
- Age compare. `older(a,b) = (a[MSB]^b[MSB]) ^ (a[MSB-1:0] < b[MSB-1:0])`. Equal ids are never older.
- Redirect candidates per cycle:
  - Integer: `in_redirect_valid & in_instr_valid`, using `in_robid` and `in_redirect_target`.
  - Memory: `mem_redirect_valid`, using `mem_redirect_robid` and `mem_redirect_target`.
  - Both present: the older one wins.
  - Equal robids: memory wins.
- Kill of the incoming instruction. It is killed if `rob_flush`, or if the memory candidate is valid and `older(mem_redirect_robid, in_robid)`.
  - A killed instruction cannot be the winning integer redirect.
  - When the memory candidate is the same instruction, the integer redirect loses.
- Capture of the winning redirect:
  - Capture sets `flush_valid=1` for exactly one cycle, with its robid and target.
  - If `rob_flush` is asserted, no redirect is captured.
- Data registers:
  - `out_instr_valid <= in_instr_valid & ~kill`.
  - Other `out_*` data fields load every cycle; their value is don't-care when invalid.
- `redirect_cnt` increments by 1 per captured redirect and wraps at 2^32; `rob_flush` does not clear it.
- No backpressure: the block accepts every cycle. The upstream block always reports ready.

## Timing
- Latency: 1 cycle from `in_*` to `out_*` and `flush_*`.
- Flush pulse: `flush_valid` is high for one cycle per captured redirect.
  - While it is high, the integer execution block suppresses younger inputs itself.
  - This block does not re-check incoming instructions against its own registered flush.
- Same-cycle events:
  - A new integer redirect arriving while `flush_valid` is high is accepted normally. The upstream block has already suppressed it if it is younger.
  - `rob_flush` in the same cycle as any redirect: the registers clear; no flush pulse and no count.
- Reset (asynchronous, any time, including mid-pulse):
  - Every output goes to 0 immediately, and all registers clear.
  - The first capture happens at the first rising edge after `reset_n` rises.
- Wrap-around: ids 7'h7F vs 7'h00 follow the flag rule above, so 7'h7F is older than 7'h00.

## Test plan
- Plain pass-through: `in_instr_valid=1`, `prd=5`, `result=64'h1234`, `robid=7'h03` → next cycle `out_instr_valid=1`, `out_prd=5`, `out_result=64'h1234`; `flush_valid=0`.
- Branch redirect: `in_redirect_valid=1`, `robid=7'h10`, `target=64'h8000_0100` → one-cycle pulse `flush_valid=1`, `flush_robid=7'h10`, `flush_target=64'h8000_0100`; `redirect_cnt` goes 0→1; the instruction itself is still valid at the output.
- Memory redirect older than integer: mem robid 7'h08, integer robid 7'h0C with redirect → `flush_robid=7'h08`, mem target; `out_instr_valid=0`; count +1 only.
- Wrap-around arbitration: mem robid 7'h41, integer robid 7'h3F with redirect → integer is older and wins; instruction kept valid.
- Global flush collision: `rob_flush=1` with a valid integer redirect → next cycle `out_instr_valid=0`, `flush_valid=0`, count unchanged.
- Asynchronous reset during a flush pulse: drop `reset_n` mid-cycle while `flush_valid=1` → all outputs 0 immediately, `redirect_cnt=0`.
